// File: rtl/ahb5_apb_pkg.sv
// Shared types and helpers for the AHB5-to-APB4 bridge.
package ahb5_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    function automatic logic [3:0] pstrb_f(input logic [2:0] hsize, input logic [1:0] addr_lo);
        case (hsize)
            HSIZE_BYTE: return 4'b0001 << addr_lo;
            HSIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    // Sizes above a word and addresses not aligned to the transfer size are rejected.
    function automatic logic xfer_err_f(input logic [2:0] hsize, input logic [1:0] addr_lo);
        case (hsize)
            HSIZE_BYTE: return 1'b0;
            HSIZE_HALF: return addr_lo[0];
            HSIZE_WORD: return |addr_lo;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/apb4_timeout_counter.sv
// Saturating wait-cycle counter for the APB ACCESS phase.
module apb4_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Flags the wait cycle that brings the count up to TIMEOUT_CYCLES.
    assign expired = (TIMEOUT_CYCLES != 0) && en && (count == CNT_MAX - 1'b1);

endmodule

// File: rtl/ahb5_to_apb4_bridge.sv
// AHB5 subordinate converting single AHB transfers into APB4 requester transfers.
// state  | meaning
// IDLE   | ready, no transfer in flight
// WDATA  | write accepted, capturing HWDATA
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase, waiting for PREADY or timeout
// DONE   | transfer finished OKAY, HRDATA valid for reads
// ERR1   | first ERROR response cycle (HREADYOUT=0)
// ERR2   | second ERROR response cycle (HREADYOUT=1)
module ahb5_to_apb4_bridge
    import ahb5_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HNONSEC,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic                  PREADY,
    input  logic                  PSLVERROR,
    input  logic [31:0]           PRDATA
);

    bridge_state_e state, state_nxt;

    logic    can_accept;
    logic    active_trans;
    logic    accept;
    logic    req_err;
    logic    tmo_en;
    logic    tmo_clr;
    logic    tmo_expired;
    logic    hreadyout_nxt;
    logic    hresp_nxt;
    logic    psel_nxt;
    logic    penable_nxt;
    htrans_e htrans;
    logic    unused_ok;

    assign htrans       = htrans_e'(HTRANS);
    assign active_trans = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign can_accept   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign accept       = can_accept && HSEL && HREADY && active_trans;
    assign req_err      = xfer_err_f(HSIZE, HADDR[1:0]);
    assign unused_ok    = ^HPROT[3:2];

    assign tmo_en  = (state == ST_ACCESS) && !PREADY;
    assign tmo_clr = (state_nxt == ST_SETUP);

    apb4_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .en     (tmo_en),
        .clr    (tmo_clr),
        .expired(tmo_expired)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (req_err) begin
                    state_nxt = ST_ERR1;
                end else begin
                    state_nxt = HWRITE ? ST_WDATA : ST_SETUP;
                end
            end
            ST_WDATA:  state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    state_nxt = PSLVERROR ? ST_ERR1 : ST_DONE;
                end else if (tmo_expired) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1:   state_nxt = ST_ERR2;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without lag.
    always_comb begin
        hreadyout_nxt = 1'b1;
        hresp_nxt     = HRESP_OKAY;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        case (state_nxt)
            ST_WDATA:  hreadyout_nxt = 1'b0;
            ST_SETUP: begin
                hreadyout_nxt = 1'b0;
                psel_nxt      = 1'b1;
            end
            ST_ACCESS: begin
                hreadyout_nxt = 1'b0;
                psel_nxt      = 1'b1;
                penable_nxt   = 1'b1;
            end
            ST_ERR1: begin
                hreadyout_nxt = 1'b0;
                hresp_nxt     = HRESP_ERROR;
            end
            ST_ERR2:   hresp_nxt = HRESP_ERROR;
            default:   ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
        end else begin
            HREADYOUT <= hreadyout_nxt;
            HRESP     <= hresp_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PSTRB  <= 4'b0000;
            PPROT  <= 3'b000;
            PWDATA <= '0;
            HRDATA <= '0;
        end else begin
            if (accept && !req_err) begin
                PADDR  <= HADDR[ADDR_WIDTH-1:0];
                PWRITE <= HWRITE;
                PSTRB  <= HWRITE ? pstrb_f(HSIZE, HADDR[1:0]) : 4'b0000;
                PPROT  <= {~HPROT[0], HNONSEC, HPROT[1]};
            end
            if (state == ST_WDATA) begin
                PWDATA <= HWDATA;
            end
            if ((state == ST_ACCESS) && PREADY && !PSLVERROR && !PWRITE) begin
                HRDATA <= PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb5_to_apb4_bridge.sv
// Directed, table-driven bench for the AHB5-to-APB4 bridge (timeout set to 4 cycles).
module tb_ahb5_to_apb4_bridge;

    localparam int K_OK     = 0;
    localparam int K_BADREQ = 1;
    localparam int K_SLVERR = 2;
    localparam int K_SKIP   = 3;
    localparam int NV       = 14;

    logic        HCLK, HRESETn, HSEL, HWRITE, HNONSEC, HREADY;
    logic [31:0] HADDR, HWDATA, PRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HREADYOUT, HRESP, PSEL, PENABLE, PWRITE, PREADY, PSLVERROR;
    logic [31:0] HRDATA, PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;

    typedef struct {
        string       name;
        logic        hsel;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [3:0]  hprot;
        logic        hnonsec;
        logic [31:0] prdata;
        logic        pslverr;
        int          kind;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } vec_t;

    vec_t vec[NV];
    vec_t v;
    int   n_chk  = 0;
    int   n_pass = 0;

    ahb5_to_apb4_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HNONSEC(HNONSEC), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PSLVERROR(PSLVERROR), .PRDATA(PRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_ctrl(input string nm, input logic psel, input logic pen,
                            input logic hrdy, input logic hrsp);
        chk({nm, " PSEL"},      32'(PSEL),      32'(psel));
        chk({nm, " PENABLE"},   32'(PENABLE),   32'(pen));
        chk({nm, " HREADYOUT"}, 32'(HREADYOUT), 32'(hrdy));
        chk({nm, " HRESP"},     32'(HRESP),     32'(hrsp));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk_ctrl(nm, 1'b0, 1'b0, 1'b1, 1'b0);
        chk({nm, " HRDATA"}, HRDATA, 32'h0);
        chk({nm, " PADDR"},  PADDR,  32'h0);
        chk({nm, " PWDATA"}, PWDATA, 32'h0);
        chk({nm, " PSTRB"},  32'(PSTRB), 32'h0);
        chk({nm, " PPROT"},  32'(PPROT), 32'h0);
        chk({nm, " PWRITE"}, 32'(PWRITE), 32'h0);
    endtask

    task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                              input logic [3:0] prot, input logic ns);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
        HPROT = prot; HNONSEC = ns;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    initial begin
        //            name             sel   trans  wr    size  addr          wdata         prot     ns    prdata        serr  kind      pstrb    pprot
        vec[0]  = '{"wr_word",       1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011, 1'b1, 32'h0,         1'b0, K_OK,     4'b1111, 3'b011};
        vec[1]  = '{"rd_byte",       1'b1, 2'b10, 1'b0, 3'd0, 32'h0000_0103, 32'h0,         4'b0001, 1'b0, 32'h1122_3344, 1'b0, K_OK,     4'b0000, 3'b000};
        vec[2]  = '{"wr_half_hi",    1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_0002, 32'h0000_BEEF, 4'b0000, 1'b1, 32'h0,         1'b0, K_OK,     4'b1100, 3'b110};
        vec[3]  = '{"wr_byte1",      1'b1, 2'b10, 1'b1, 3'd0, 32'h0000_0001, 32'h1234_5678, 4'b0010, 1'b0, 32'h0,         1'b0, K_OK,     4'b0010, 3'b101};
        vec[4]  = '{"wr_byte3",      1'b1, 2'b10, 1'b1, 3'd0, 32'h0000_0007, 32'h8765_4321, 4'b0000, 1'b0, 32'h0,         1'b0, K_OK,     4'b1000, 3'b100};
        vec[5]  = '{"rd_word_seq",   1'b1, 2'b11, 1'b0, 3'd2, 32'h0000_0200, 32'h0,         4'b0011, 1'b1, 32'hA5A5_5A5A, 1'b0, K_OK,     4'b0000, 3'b011};
        vec[6]  = '{"rd_half",       1'b1, 2'b10, 1'b0, 3'd1, 32'h0000_0006, 32'h0,         4'b0000, 1'b0, 32'hCAFE_F00D, 1'b0, K_OK,     4'b0000, 3'b100};
        vec[7]  = '{"half_misalign", 1'b1, 2'b10, 1'b0, 3'd1, 32'h0000_0005, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b0, K_BADREQ, 4'b0000, 3'b000};
        vec[8]  = '{"size3",         1'b1, 2'b10, 1'b1, 3'd3, 32'h0000_0000, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b0, K_BADREQ, 4'b0000, 3'b000};
        vec[9]  = '{"word_misalign", 1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0002, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b0, K_BADREQ, 4'b0000, 3'b000};
        vec[10] = '{"wr_slverr",     1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0044, 32'h0F0F_0F0F, 4'b0000, 1'b0, 32'h0,         1'b1, K_SLVERR, 4'b1111, 3'b100};
        vec[11] = '{"busy",          1'b1, 2'b01, 1'b0, 3'd2, 32'h0000_0010, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b0, K_SKIP,   4'b0000, 3'b000};
        vec[12] = '{"unselected",    1'b0, 2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b0, K_SKIP,   4'b0000, 3'b000};
        vec[13] = '{"idle_badsize",  1'b1, 2'b00, 1'b0, 3'd3, 32'h0000_0001, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b0, K_SKIP,   4'b0000, 3'b000};

        HRESETn = 1'b0; HREADY = 1'b1; HWDATA = '0; PRDATA = '0;
        PREADY = 1'b1; PSLVERROR = 1'b0; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0;
        HPROT = 4'b0000; HNONSEC = 1'b0;
        bus_idle();
        #23;
        chk_reset_vals("reset");
        step();
        HRESETn = 1'b1;
        step();

        // Byte read with three wait states.
        addr_phase(1'b0, 3'd0, 32'h0000_0103, 4'b0000, 1'b0);
        PREADY = 1'b0; PRDATA = 32'h1122_3344;
        step();
        bus_idle();
        chk_ctrl("wait_rd setup", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wait_rd PADDR", PADDR, 32'h0000_0103);
        chk("wait_rd PSTRB", 32'(PSTRB), 32'h0);
        step();
        for (int k = 0; k < 3; k++) begin
            chk_ctrl($sformatf("wait_rd access%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("wait_rd access%0d PSTRB", k), 32'(PSTRB), 32'h0);
            step();
        end
        chk_ctrl("wait_rd access3", 1'b1, 1'b1, 1'b0, 1'b0);
        PREADY = 1'b1;
        step();
        chk_ctrl("wait_rd done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wait_rd HRDATA", HRDATA, 32'h1122_3344);
        step();

        for (int i = 0; i < NV; i++) begin
            v = vec[i];
            HSEL = v.hsel; HTRANS = v.htrans; HWRITE = v.hwrite; HSIZE = v.hsize;
            HADDR = v.haddr; HWDATA = v.hwdata; HPROT = v.hprot; HNONSEC = v.hnonsec;
            PRDATA = v.prdata; PSLVERROR = v.pslverr; PREADY = 1'b1;
            step();
            bus_idle();
            if (v.kind == K_SKIP) begin
                chk_ctrl({v.name, " skip"}, 1'b0, 1'b0, 1'b1, 1'b0);
            end else if (v.kind == K_BADREQ) begin
                chk_ctrl({v.name, " err1"}, 1'b0, 1'b0, 1'b0, 1'b1);
                step();
                chk_ctrl({v.name, " err2"}, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
                if (v.hwrite) begin
                    chk_ctrl({v.name, " wdata"}, 1'b0, 1'b0, 1'b0, 1'b0);
                    step();
                end
                chk_ctrl({v.name, " setup"}, 1'b1, 1'b0, 1'b0, 1'b0);
                chk({v.name, " PADDR"},  PADDR, v.haddr);
                chk({v.name, " PSTRB"},  32'(PSTRB), 32'(v.pstrb));
                chk({v.name, " PPROT"},  32'(PPROT), 32'(v.pprot));
                chk({v.name, " PWRITE"}, 32'(PWRITE), 32'(v.hwrite));
                if (v.hwrite) chk({v.name, " PWDATA"}, PWDATA, v.hwdata);
                step();
                chk_ctrl({v.name, " access"}, 1'b1, 1'b1, 1'b0, 1'b0);
                step();
                if (v.kind == K_OK) begin
                    chk_ctrl({v.name, " done"}, 1'b0, 1'b0, 1'b1, 1'b0);
                    if (!v.hwrite) chk({v.name, " HRDATA"}, HRDATA, v.prdata);
                end else begin
                    chk_ctrl({v.name, " err1"}, 1'b0, 1'b0, 1'b0, 1'b1);
                    step();
                    chk_ctrl({v.name, " err2"}, 1'b0, 1'b0, 1'b1, 1'b1);
                end
            end
            PSLVERROR = 1'b0;
            step();
            step();
            chk_ctrl({v.name, " idle"}, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Read followed by a write presented during DONE.
        addr_phase(1'b0, 3'd2, 32'h0000_0010, 4'b0000, 1'b0);
        PRDATA = 32'h0BAD_CAFE;
        step();
        bus_idle();
        step();
        step();
        chk_ctrl("b2b rd done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b rd HRDATA", HRDATA, 32'h0BAD_CAFE);
        addr_phase(1'b1, 3'd1, 32'h0000_0002, 4'b0000, 1'b0);
        step();
        bus_idle();
        HWDATA = 32'h5555_AAAA;
        chk_ctrl("b2b wr wdata", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_ctrl("b2b wr setup", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b wr PSTRB", 32'(PSTRB), 32'hC);
        chk("b2b wr PWDATA", PWDATA, 32'h5555_AAAA);
        chk("b2b wr PADDR", PADDR, 32'h0000_0002);
        step();
        step();
        chk_ctrl("b2b wr done", 1'b0, 1'b0, 1'b1, 1'b0);
        step();

        // Write with PREADY stuck low hits the 4-cycle timeout.
        addr_phase(1'b1, 3'd2, 32'h0000_0080, 4'b0000, 1'b0);
        HWDATA = 32'h1357_9BDF; PREADY = 1'b0;
        step();
        bus_idle();
        step();
        chk_ctrl("tmo setup", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk_ctrl($sformatf("tmo access%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_ctrl("tmo err1", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_ctrl("tmo err2", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_ctrl("tmo idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset asserted in the middle of ACCESS.
        addr_phase(1'b0, 3'd2, 32'h0000_0020, 4'b0011, 1'b1);
        step();
        bus_idle();
        step();
        chk_ctrl("rst access", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_reset_vals("rst mid");
        step();
        step();
        HRESETn = 1'b1;
        PREADY = 1'b1;
        step();
        chk_ctrl("rst after", 1'b0, 1'b0, 1'b1, 1'b0);
        addr_phase(1'b0, 3'd2, 32'h0000_0030, 4'b0000, 1'b0);
        PRDATA = 32'h600D_F00D;
        step();
        bus_idle();
        step();
        step();
        chk_ctrl("rst rd done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst rd HRDATA", HRDATA, 32'h600D_F00D);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
